// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings: forwarding-mux selects and result-source selects.
// Imported by the ID/EX register, the execute operand muxes and the hazard/forward unit.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter that holds at all-ones instead of wrapping.
// Latency: q reflects inc one cycle later; rst takes priority over clr, and clr over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall and branch flush control, with stall/flush event counters.
// Latency: controls are combinational (0 cycles); M/W shadows and counters update on posedge.
module hazard_forward_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic [REG_AW-1:0] RdM, RdW;
  logic              RegWriteM, RegWriteW;
  logic              lw_stall;
  logic              eff_stall;

  // Bubbles reach here as RegWriteE=0 from the cleared ID/EX, so the shadows never stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      RdM       <= '0;
      RdW       <= '0;
      RegWriteM <= 1'b0;
      RegWriteW <= 1'b0;
    end else begin
      RdM       <= RdE;
      RegWriteM <= RegWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == src)) begin
      return FWD_MEM;
    end else if (we_w && (rd_w != '0) && (rd_w == src)) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

  assign lw_stall  = (ResultSrcE == RES_LOAD) && RegWriteE && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  // A taken branch squashes the Decode instruction, so its load-use hazard is moot.
  assign eff_stall = lw_stall && !PCSrcE;

  always_comb begin
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (eff_stall),
    .q   (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (PCSrcE),
    .q   (FlushCount)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboarded bench for hazard_forward_unit: directed cases then random traffic vs a reference model.
module tb_hazard_forward_unit;

  localparam int CW = 4;
  localparam int AW = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic          RegWriteE;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE;
  logic          cnt_clr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] StallCount, FlushCount;

  always #5 clk = ~clk;

  hazard_forward_unit #(.CNT_W(CW), .REG_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .cnt_clr    (cnt_clr),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          sf;
    logic          sd;
    logic          fd;
    logic          fe;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: the last two retired writers, newest first (index 0 = M, 1 = W).
  logic [AW-1:0] hist_rd[2];
  logic          hist_we[2];
  int            m_sc, m_fc;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] s);
    for (int i = 0; i < 2; i++) begin
      if (hist_we[i] && hist_rd[i] != 0 && hist_rd[i] == s) return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic step();
    exp_t e;
    logic lw;
    lw = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    e = '0;
    e.sc = m_sc[CW-1:0];
    e.fc = m_fc[CW-1:0];
    if (rst) begin
      e.fd = 1'b1;
      e.fe = 1'b1;
    end else begin
      e.fa = ref_fwd(Rs1E);
      e.fb = ref_fwd(Rs2E);
      if (PCSrcE) begin
        e.fd = 1'b1;
        e.fe = 1'b1;
      end else if (lw) begin
        e.sf = 1'b1;
        e.sd = 1'b1;
        e.fe = 1'b1;
      end
    end
    expq.push_back(e);
    @(posedge clk);
    if (rst) begin
      hist_rd[0] = 0; hist_rd[1] = 0;
      hist_we[0] = 0; hist_we[1] = 0;
      m_sc = 0; m_fc = 0;
    end else begin
      if (cnt_clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (lw && !PCSrcE && m_sc < SAT) m_sc++;
        if (PCSrcE && m_fc < SAT) m_fc++;
      end
      hist_rd[1] = hist_rd[0]; hist_we[1] = hist_we[0];
      hist_rd[0] = RdE;        hist_we[0] = RegWriteE;
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] rs1d, input logic [AW-1:0] rs2d,
                       input logic [AW-1:0] rs1e, input logic [AW-1:0] rs2e,
                       input logic [AW-1:0] rde, input logic we, input logic [1:0] res,
                       input logic pc, input logic clr, input logic r);
    Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e; RdE = rde;
    RegWriteE = we; ResultSrcE = res; PCSrcE = pc; cnt_clr = clr; rst = r;
    step();
  endtask

  exp_t mon_e, mon_g;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      mon_g = '{ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, StallCount, FlushCount};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d want fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b sc=%0d fc=%0d",
                 cyc, mon_g.fa, mon_g.fb, mon_g.sf, mon_g.sd, mon_g.fd, mon_g.fe, mon_g.sc, mon_g.fc,
                 mon_e.fa, mon_e.fb, mon_e.sf, mon_e.sd, mon_e.fd, mon_e.fe, mon_e.sc, mon_e.fc);
      end
    end
  end

  initial begin
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; cnt_clr = 0; rst = 1;
    // Unchecked reset edge brings the DUT out of X before the model takes over.
    @(posedge clk);
    #1;
    hist_rd[0] = 0; hist_rd[1] = 0; hist_we[0] = 0; hist_we[1] = 0;
    m_sc = 0; m_fc = 0;

    // Reset state is checked while rst is still high.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // M forward, then W forward, then M beats W.
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);

    // Load-use stall, its release, and a branch overriding it.
    drive(0, 6, 0, 0, 6, 1, 2'b01, 0, 0, 0);
    drive(0, 6, 0, 0, 6, 0, 2'b01, 0, 0, 0);
    drive(0, 6, 0, 0, 6, 1, 2'b01, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Writes to x0 are never forwarded and never stall.
    drive(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation of the stall counter, then clear beating increment.
    for (int i = 0; i < 20; i++) drive(6, 0, 0, 0, 6, 1, 2'b01, 0, 0, 0);
    drive(6, 0, 0, 0, 6, 1, 2'b01, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream drops the in-flight writer.
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(0, 0, 5, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 5, 5, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      drive(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 47) == 0), ($urandom_range(0, 79) == 0));
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
